// File: rtl/view_scroller.sv
// view_scroller: rate-limited camera scroll, fall detection and
// platform-row spawn queue with a valid/ready handshake.
module view_scroller #(
  parameter int W             = 32,
  parameter int SCREEN_HEIGHT = 700,
  parameter int SCROLL_LINE   = 350,
  parameter int MAX_STEP      = 8,
  parameter int ROW_SPACING   = 50,
  parameter int PEND_DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         frame_tick,
  input  logic [W-1:0] doodle_y,
  output logic [W-1:0] view_y,
  output logic [W-1:0] scroll_step,
  output logic         new_view,
  output logic         game_over,
  output logic         running,
  output logic         spawn_valid,
  input  logic         spawn_ready,
  output logic [W-1:0] spawn_y,
  output logic         spawn_overflow
);

  localparam int PW = $clog2(PEND_DEPTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam logic [W:0] LINE_W = (W+1)'(SCROLL_LINE);
  localparam logic [W:0] STEP_W = (W+1)'(MAX_STEP);
  localparam logic [W:0] ROW_W  = (W+1)'(ROW_SPACING);
  localparam logic [W:0] ALL1_W = {1'b0, {W{1'b1}}};
  localparam logic [W:0] VMAX   = ALL1_W - (W+1)'(SCREEN_HEIGHT);

  localparam logic [W-1:0] ROW_N  = W'(ROW_SPACING);
  localparam logic [W-1:0] SCR_N  = W'(SCREEN_HEIGHT);
  localparam logic [PW-1:0] PFULL = PW'(PEND_DEPTH);
  localparam logic [PW-1:0] PONE  = PW'(1);

  logic [1:0]    state;
  logic [W-1:0]  acc;
  logic [PW-1:0] pending;
  logic [W-1:0]  next_row_y;

  logic [W:0]    doodle_w;
  logic [W:0]    view_w;
  logic [W:0]    line_w;
  logic [W:0]    room;
  logic [W:0]    step;
  logic [W:0]    acc_n;
  logic [W:0]    acc_nx;
  logic          fall;
  logic          above;
  logic          evaluate;
  logic          scroll;
  logic          enq;
  logic          accept;
  logic          restart;
  logic          full;

  // Widened compare operands so view_y + SCROLL_LINE never wraps.
  assign doodle_w = {1'b0, doodle_y};
  assign view_w   = {1'b0, view_y};
  assign line_w   = view_w + LINE_W;
  assign room     = VMAX - view_w;

  assign fall     = doodle_w < view_w;
  assign above    = doodle_w > line_w;
  assign evaluate = (state == RUN) & frame_tick;
  assign scroll   = evaluate & ~fall;
  assign restart  = (state == OVER) & start;

  assign spawn_valid = pending != '0;
  assign spawn_y     = next_row_y;
  assign accept      = spawn_valid & spawn_ready;
  assign full        = pending == PFULL;

  assign game_over = state == OVER;
  assign running   = state == RUN;

  // Step is the distance past the line, clipped by rate and headroom.
  always_comb begin
    step = '0;
    if (above) begin
      step = doodle_w - line_w;
      if (step > STEP_W) step = STEP_W;
      if (step > room) step = room;
    end
  end

  // Row-distance accumulator; wraps once per spawned row.
  always_comb begin
    acc_n  = {1'b0, acc} + step;
    acc_nx = acc_n;
    enq    = 1'b0;
    if (scroll && acc_n >= ROW_W) begin
      acc_nx = acc_n - ROW_W;
      enq    = 1'b1;
    end
  end

  // Top-level state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (evaluate && fall) state <= OVER;
        OVER:    if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Camera position and scroll accumulator.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      view_y <= '0;
      acc    <= '0;
    end else if (scroll) begin
      view_y <= view_y + step[W-1:0];
      acc    <= acc_nx[W-1:0];
    end
  end

  // Per-tick step report and single-cycle change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_step <= '0;
      new_view    <= 1'b0;
    end else begin
      new_view <= scroll & (step != '0);
      if (evaluate) scroll_step <= fall ? '0 : step[W-1:0];
    end
  end

  // Spawn queue: pending count, offered row and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pending        <= '0;
      next_row_y     <= SCR_N;
      spawn_overflow <= 1'b0;
    end else begin
      if (accept) next_row_y <= next_row_y + ROW_N;
      unique case ({enq, accept})
        2'b10: begin
          if (full) spawn_overflow <= 1'b1;
          else      pending <= pending + PONE;
        end
        2'b01:   pending <= pending - PONE;
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_view_scroller.sv
// tb_view_scroller: directed vectors for view_scroller
// with hand-computed expectations (W=12, VMAX=3395).
module tb_view_scroller;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         frame_tick;
  logic [W-1:0] doodle_y;
  logic [W-1:0] view_y;
  logic [W-1:0] scroll_step;
  logic         new_view;
  logic         game_over;
  logic         running;
  logic         spawn_valid;
  logic         spawn_ready;
  logic [W-1:0] spawn_y;
  logic         spawn_overflow;

  int total = 0;
  int bad   = 0;

  view_scroller #(.W(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .frame_tick(frame_tick),
    .doodle_y(doodle_y),
    .view_y(view_y),
    .scroll_step(scroll_step),
    .new_view(new_view),
    .game_over(game_over),
    .running(running),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_y(spawn_y),
    .spawn_overflow(spawn_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick(input logic [W-1:0] y, input logic rdy);
    doodle_y    = y;
    frame_tick  = 1'b1;
    spawn_ready = rdy;
    cyc();
    frame_tick  = 1'b0;
    spawn_ready = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    frame_tick  = 1'b0;
    doodle_y    = '0;
    spawn_ready = 1'b0;
    @(negedge clk);
    cyc();
    reset = 1'b0;

    chk("rst_view", view_y, 0);
    chk("rst_step", scroll_step, 0);
    chk("rst_nv", new_view, 0);
    chk("rst_run", running, 0);
    chk("rst_over", game_over, 0);
    chk("rst_valid", spawn_valid, 0);
    chk("rst_sy", spawn_y, 700);
    chk("rst_ovf", spawn_overflow, 0);

    tick(12'd1000, 1'b0);
    chk("idle_ignore", view_y, 0);

    pulse_start();
    chk("start_run", running, 1);

    // below the line: no movement
    for (int i = 0; i < 3; i++) begin
      tick(12'd300, 1'b0);
      chk("t1_view", view_y, 0);
      chk("t1_nv", new_view, 0);
    end
    chk("t1_valid", spawn_valid, 0);

    // small step then rate-limited step
    tick(12'd355, 1'b0);
    chk("t2_view", view_y, 5);
    chk("t2_step", scroll_step, 5);
    chk("t2_nv", new_view, 1);
    cyc();
    chk("t2_nv_clr", new_view, 0);
    tick(12'd400, 1'b0);
    chk("t2_clip_view", view_y, 13);
    chk("t2_clip_step", scroll_step, 8);

    // fresh start: seven full steps -> first spawn
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) tick(12'd1000, 1'b0);
    chk("t3_nospawn", spawn_valid, 0);
    tick(12'd1000, 1'b0);
    chk("t3_valid", spawn_valid, 1);
    chk("t3_sy", spawn_y, 700);
    chk("t3_view", view_y, 56);
    cyc();
    chk("t3_hold_v", spawn_valid, 1);
    chk("t3_hold_y", spawn_y, 700);
    spawn_ready = 1'b1;
    cyc();
    spawn_ready = 1'b0;
    chk("t3_acc_v", spawn_valid, 0);
    chk("t3_acc_y", spawn_y, 750);

    // fill queue to 4 (acc 6 -> 246 over 30 ticks)
    for (int i = 0; i < 30; i++) tick(12'd1000, 1'b0);
    chk("t4_valid", spawn_valid, 1);
    chk("t4_ovf0", spawn_overflow, 0);
    chk("t4_sy", spawn_y, 750);
    // enqueue + accept at full
    tick(12'd1000, 1'b1);
    chk("t4_both_ovf", spawn_overflow, 0);
    chk("t4_both_sy", spawn_y, 800);
    for (int i = 0; i < 5; i++) tick(12'd1000, 1'b0);
    chk("t4_pre_ovf", spawn_overflow, 0);
    tick(12'd1000, 1'b0);
    chk("t4_ovf", spawn_overflow, 1);
    chk("t4_view", view_y, 352);

    // fall
    tick(12'd351, 1'b0);
    chk("t5_over", game_over, 1);
    chk("t5_run", running, 0);
    chk("t5_view", view_y, 352);
    chk("t5_step", scroll_step, 0);
    tick(12'd2000, 1'b0);
    chk("t5_ign_view", view_y, 352);
    chk("t5_ign_nv", new_view, 0);
    // drain the four pending rows while OVER
    spawn_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("t5_drain3_v", spawn_valid, 1);
    chk("t5_drain3_y", spawn_y, 950);
    cyc();
    chk("t5_drain4_v", spawn_valid, 0);
    chk("t5_drain4_y", spawn_y, 1000);
    cyc();
    chk("t5_idle_rdy", spawn_y, 1000);
    spawn_ready = 1'b0;
    chk("t5_ovf_kept", spawn_overflow, 1);
    pulse_start();
    chk("t5_rs_run", running, 1);
    chk("t5_rs_over", game_over, 0);
    chk("t5_rs_view", view_y, 0);
    chk("t5_rs_ovf", spawn_overflow, 0);
    chk("t5_rs_sy", spawn_y, 700);
    chk("t5_rs_valid", spawn_valid, 0);

    // two pending rows, then edge cases and mid-scroll reset
    for (int i = 0; i < 13; i++) tick(12'd1000, 1'b0);
    chk("t6_view", view_y, 104);
    chk("t6_valid", spawn_valid, 1);
    tick(12'd104, 1'b0);
    chk("t6_eq_run", running, 1);
    chk("t6_eq_step", scroll_step, 0);
    tick(12'd454, 1'b0);
    chk("t6_line_view", view_y, 104);
    chk("t6_line_nv", new_view, 0);
    tick(12'd455, 1'b0);
    chk("t6_one_view", view_y, 105);
    chk("t6_one_nv", new_view, 1);
    doodle_y   = 12'd1000;
    frame_tick = 1'b1;
    reset      = 1'b1;
    cyc();
    reset      = 1'b0;
    frame_tick = 1'b0;
    chk("t6_rst_view", view_y, 0);
    chk("t6_rst_step", scroll_step, 0);
    chk("t6_rst_nv", new_view, 0);
    chk("t6_rst_run", running, 0);
    chk("t6_rst_over", game_over, 0);
    chk("t6_rst_valid", spawn_valid, 0);
    chk("t6_rst_sy", spawn_y, 700);
    chk("t6_rst_ovf", spawn_overflow, 0);

    // saturation at VMAX = 4095 - 700 = 3395
    pulse_start();
    for (int i = 0; i < 424; i++) tick(12'd4095, 1'b1);
    chk("sat_pre", view_y, 3392);
    tick(12'd4095, 1'b1);
    chk("sat_view", view_y, 3395);
    chk("sat_step", scroll_step, 3);
    chk("sat_nv", new_view, 1);
    tick(12'd4095, 1'b1);
    chk("sat_hold", view_y, 3395);
    chk("sat_step0", scroll_step, 0);
    chk("sat_nv0", new_view, 0);
    chk("sat_ovf", spawn_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
